automaton_symbol_feeder: RTL and testbench

Front-end streamer that feeds the STE automaton array. It accepts the raw input byte stream with a valid/ready handshake and packs consecutive bytes into 16-bit symbols; the first byte of each pair goes in [15:8], the second in [7:0]. Symbols are buffered in a small FIFO and presented one per cycle to the STE bank's `character` input, with stall support, odd-length padding, a symbol index for report tagging, and an end-of-stream marker.

---
 rtl/automaton_symbol_feeder.sv | 133 +++++++++++++
 tb/tb_automaton_symbol_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/automaton_symbol_feeder.sv
// Byte-to-symbol packer and FIFO streamer feeding the STE automaton array.
// Pairs bytes into 16-bit symbols, pads odd streams, tags index and end.
module automaton_symbol_feeder #(
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      character,
    output logic             sym_valid,
    output logic             sym_half,
    output logic             sym_last,
    output logic [CNT_W-1:0] sym_index,
    input  logic             sym_ready,
    output logic             done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hi_q;
    logic [15:0]     mem_data [FIFO_DEPTH];
    logic            mem_half [FIFO_DEPTH];
    logic            mem_last [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CNT_W-1:0] idx_q;
    logic            done_q;

    logic            fifo_empty, fifo_full;
    logic            xfer, pop, head_last;
    logic            push, push_half, push_last, hi_load;
    logic [15:0]     push_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign in_ready   = (state_q != DRAIN) && !fifo_full && reset_n;
    assign sym_valid  = !fifo_empty;
    assign xfer       = in_valid && in_ready;
    assign pop        = sym_valid && sym_ready;
    assign head_last  = mem_last[rd_ptr_q];

    // Head fields are masked so an empty FIFO never exposes stale entries.
    assign character = fifo_empty ? 16'h0000 : mem_data[rd_ptr_q];
    assign sym_half  = !fifo_empty && mem_half[rd_ptr_q];
    assign sym_last  = !fifo_empty && head_last;
    assign sym_index = idx_q;
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = 16'h0000;
        push_half = 1'b0;
        push_last = 1'b0;
        hi_load   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (xfer) begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_data = {in_byte, PAD_BYTE};
                        push_half = 1'b1;
                        push_last = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        hi_load = 1'b1;
                        state_d = HALF;
                    end
                end
            end
            HALF: begin
                if (xfer) begin
                    push      = 1'b1;
                    push_data = {hi_q, in_byte};
                    push_last = in_last;
                    state_d   = in_last ? DRAIN : EMPTY;
                end
            end
            DRAIN: begin
                if (pop && head_last) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            hi_q     <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= pop && head_last;
            if (hi_load) hi_q <= in_byte;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                idx_q    <= head_last ? '0 : idx_q + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_half[wr_ptr_q] <= push_half;
            mem_last[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: tb/tb_automaton_symbol_feeder.sv
// Directed bench for automaton_symbol_feeder (FIFO_DEPTH=4, CNT_W=3).
// Linear step sequence with immediate-assertion checks.
module tb_automaton_symbol_feeder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] character;
    logic        sym_valid;
    logic        sym_half;
    logic        sym_last;
    logic [2:0]  sym_index;
    logic        sym_ready;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] bt [0:63];

    automaton_symbol_feeder #(
        .PAD_BYTE  (8'h00),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .character(character),
        .sym_valid(sym_valid),
        .sym_half (sym_half),
        .sym_last (sym_last),
        .sym_index(sym_index),
        .sym_ready(sym_ready),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Streams bt[0..n-1] (n even) and checks every presented symbol.
    task automatic stream(input int n, input bit rnd, input int limit);
        int sent = 0;
        int pops = 0;
        int dn = 0;
        int c = 0;
        int nsym = n / 2;
        logic xfer;
        while (c < limit && (pops < nsym || dn == 0)) begin
            in_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            in_byte = 8'h00;
            if (sent < n) in_byte = bt[sent];
            in_last = (sent == n - 1);
            sym_ready = !rnd || ($urandom_range(0, 1) == 1);
            if (done) dn++;
            if (sym_valid) begin
                if (pops < nsym) begin
                    chk("stream_char", 32'(character),
                        {16'h0, bt[2*pops], bt[2*pops+1]});
                    chk("stream_idx", 32'(sym_index), 32'(pops % 8));
                    chk("stream_last", 32'(sym_last), 32'(pops == nsym - 1));
                end else begin
                    chk("stream_extra_sym", 32'(sym_valid), 32'd0);
                end
                if (sym_ready) pops++;
            end
            xfer = in_valid && in_ready;
            tick();
            if (xfer) sent++;
            c++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sym_ready = 1'b0;
        chk("stream_pops", 32'(pops), 32'(nsym));
        chk("stream_sent", 32'(sent), 32'(n));
        chk("stream_done", 32'(dn), 32'd1);
    endtask

    initial begin
        int sent;
        int pops;
        logic xfer;

        reset_n   = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sym_ready = 1'b0;
        tick();
        tick();
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_char", 32'(character), 32'd0);
        chk("rst_half", 32'(sym_half), 32'd0);
        chk("rst_last", 32'(sym_last), 32'd0);
        chk("rst_idx", 32'(sym_index), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Even stream 41 41 43 43
        sym_ready = 1'b1;
        send(8'h41, 1'b0);
        chk("s1_no_sym", 32'(sym_valid), 32'd0);
        send(8'h41, 1'b0);
        chk("s1_char0", 32'(character), 32'h4141);
        chk("s1_idx0", 32'(sym_index), 32'd0);
        chk("s1_valid0", 32'(sym_valid), 32'd1);
        send(8'h43, 1'b0);
        send(8'h43, 1'b1);
        chk("s1_char1", 32'(character), 32'h4343);
        chk("s1_idx1", 32'(sym_index), 32'd1);
        chk("s1_last1", 32'(sym_last), 32'd1);
        chk("s1_drain_ready", 32'(in_ready), 32'd0);
        tick();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_idx_clr", 32'(sym_index), 32'd0);
        chk("s1_empty", 32'(sym_valid), 32'd0);
        chk("s1_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("s1_done_pulse", 32'(done), 32'd0);

        // Odd stream 41 43 41, padded
        sym_ready = 1'b0;
        send(8'h41, 1'b0);
        send(8'h43, 1'b0);
        chk("s2_char0", 32'(character), 32'h4143);
        chk("s2_half0", 32'(sym_half), 32'd0);
        chk("s2_idx0", 32'(sym_index), 32'd0);
        send(8'h41, 1'b1);
        chk("s2_drain_ready", 32'(in_ready), 32'd0);
        chk("s2_hold_char", 32'(character), 32'h4143);
        sym_ready = 1'b1;
        tick();
        chk("s2_char1", 32'(character), 32'h4100);
        chk("s2_half1", 32'(sym_half), 32'd1);
        chk("s2_last1", 32'(sym_last), 32'd1);
        chk("s2_idx1", 32'(sym_index), 32'd1);
        chk("s2_drain_ready2", 32'(in_ready), 32'd0);
        tick();
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_ready_back", 32'(in_ready), 32'd1);
        sym_ready = 1'b0;
        tick();
        chk("s2_done_pulse", 32'(done), 32'd0);

        // Back-pressure: FIFO fills after 8 bytes
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            in_byte  = 8'h10 + 8'(sent);
            in_valid = 1'b1;
            xfer = in_ready;
            tick();
            if (xfer) sent++;
        end
        chk("s3_sent_full", 32'(sent), 32'd8);
        chk("s3_full_ready", 32'(in_ready), 32'd0);
        chk("s3_head", 32'(character), 32'h1011);
        sym_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && (pops < 5 || sent < 10); c++) begin
            in_valid = (sent < 10);
            in_byte  = 8'h10 + 8'(sent);
            if (sym_valid) begin
                chk("s3_char", 32'(character),
                    {16'h0, 8'h10 + 8'(2*pops), 8'h11 + 8'(2*pops)});
                chk("s3_idx", 32'(sym_index), 32'(pops));
                pops++;
            end
            xfer = in_valid && in_ready;
            tick();
            if (xfer) sent++;
        end
        in_valid  = 1'b0;
        sym_ready = 1'b0;
        chk("s3_pops", 32'(pops), 32'd5);
        chk("s3_sent", 32'(sent), 32'd10);

        // Reset mid-stream: HALF with two symbols queued
        for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 1'b0);
        chk("s5_queued_valid", 32'(sym_valid), 32'd1);
        chk("s5_queued_head", 32'(character), 32'h2021);
        chk("s5_queued_idx", 32'(sym_index), 32'd5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(sym_valid), 32'd0);
        chk("s5_rst_ready", 32'(in_ready), 32'd1);
        chk("s5_rst_idx", 32'(sym_index), 32'd0);
        chk("s5_rst_char", 32'(character), 32'd0);
        send(8'h47, 1'b0);
        send(8'h54, 1'b1);
        chk("s5_char", 32'(character), 32'h4754);
        chk("s5_idx", 32'(sym_index), 32'd0);
        chk("s5_last", 32'(sym_last), 32'd1);
        chk("s5_half", 32'(sym_half), 32'd0);
        sym_ready = 1'b1;
        tick();
        chk("s5_done", 32'(done), 32'd1);
        sym_ready = 1'b0;
        tick();

        // 10-symbol stream: index wraps 0..7,0,1
        for (int i = 0; i < 20; i++) bt[i] = 8'(i * 7 + 3);
        stream(20, 1'b0, 100);
        tick();

        // 64-byte stream with random gaps and stalls
        for (int i = 0; i < 64; i++) bt[i] = 8'($urandom);
        stream(64, 1'b1, 2000);
        tick();
        chk("final_idle", 32'(sym_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
